// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a no-backpressure primary write stream with a queued
// secondary stream onto one registered register-file write port. Queued entries
// that are overtaken by a newer primary write to the same register are killed so
// the stale value can never land after the fresh one.
module writeback_arbiter #(
    parameter int unsigned WORD_LEN      = 32,
    parameter int unsigned REG_IDX_WIDTH = 5,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_valid,
    input  logic [REG_IDX_WIDTH-1:0] p_addr,
    input  logic [WORD_LEN-1:0]      p_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [REG_IDX_WIDTH-1:0] s_addr,
    input  logic [WORD_LEN-1:0]      s_data,
    output logic                     writeEnable,
    output logic [REG_IDX_WIDTH-1:0] writeAddr,
    output logic [WORD_LEN-1:0]      writeData,
    input  logic [REG_IDX_WIDTH-1:0] qAddr1,
    input  logic [REG_IDX_WIDTH-1:0] qAddr2,
    output logic                     qPending1,
    output logic                     qPending2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [REG_IDX_WIDTH-1:0] entryAddrQ [DEPTH];
    logic [WORD_LEN-1:0]      entryDataQ [DEPTH];
    logic [DEPTH-1:0]         validQ, validD;
    logic [DEPTH-1:0]         killQ, killD;
    logic [PtrW-1:0]          headQ, headD;
    logic [PtrW-1:0]          tailQ, tailD;
    logic [CntW-1:0]          countQ, countD;
    logic                     wrEnQ, wrEnD;
    logic [REG_IDX_WIDTH-1:0] wrAddrQ, wrAddrD;
    logic [WORD_LEN-1:0]      wrDataQ, wrDataD;

    logic primEff;
    logic pushEn;
    logic popEn;

    // Handshake and selection decisions, all from registered state
    always_comb begin
        s_ready = (countQ != CntW'(DEPTH));
        primEff = p_valid && (p_addr != '0);
        // x0 writes complete the handshake but are dropped
        pushEn  = s_valid && s_ready && (s_addr != '0);
        // Only entries already counted can pop, so a same-cycle push never bypasses
        popEn   = !primEff && (countQ != '0);
    end

    // Next-state: output selection, kill marking, pointer and occupancy update
    always_comb begin
        validD  = validQ;
        killD   = killQ;
        headD   = headQ;
        tailD   = tailQ;
        wrEnD   = 1'b0;
        wrAddrD = wrAddrQ;
        wrDataD = wrDataQ;
        if (primEff) begin
            wrEnD   = 1'b1;
            wrAddrD = p_addr;
            wrDataD = p_data;
            // Older queued writes to this register are now stale
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (validQ[i] && (entryAddrQ[i] == p_addr)) begin
                    killD[i] = 1'b1;
                end
            end
        end else if (popEn) begin
            // A killed head still uses the slot but leaves the port idle
            if (!killQ[headQ]) begin
                wrEnD   = 1'b1;
                wrAddrD = entryAddrQ[headQ];
                wrDataD = entryDataQ[headQ];
            end
            validD[headQ] = 1'b0;
            killD[headQ]  = 1'b0;
            headD         = headQ + 1'b1;
        end
        // Push after kill marking so the new entry counts as younger
        if (pushEn) begin
            validD[tailQ] = 1'b1;
            killD[tailQ]  = 1'b0;
            tailD         = tailQ + 1'b1;
        end
        countD = countQ + CntW'(pushEn) - CntW'(popEn);
    end

    // Control state and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ  <= '0;
            killQ   <= '0;
            headQ   <= '0;
            tailQ   <= '0;
            countQ  <= '0;
            wrEnQ   <= 1'b0;
            wrAddrQ <= '0;
            wrDataQ <= '0;
        end else begin
            validQ  <= validD;
            killQ   <= killD;
            headQ   <= headD;
            tailQ   <= tailD;
            countQ  <= countD;
            wrEnQ   <= wrEnD;
            wrAddrQ <= wrAddrD;
            wrDataQ <= wrDataD;
        end
    end

    // Payload storage; qualified by the valid bits so it needs no reset
    always_ff @(posedge clk) begin
        if (pushEn) begin
            entryAddrQ[tailQ] <= s_addr;
            entryDataQ[tailQ] <= s_data;
        end
    end

    // Decode hazard query over live (valid, not killed) queue entries
    always_comb begin
        qPending1 = 1'b0;
        qPending2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (validQ[i] && !killQ[i]) begin
                if ((qAddr1 != '0) && (entryAddrQ[i] == qAddr1)) qPending1 = 1'b1;
                if ((qAddr2 != '0) && (entryAddrQ[i] == qAddr2)) qPending2 = 1'b1;
            end
        end
    end

    assign writeEnable = wrEnQ;
    assign writeAddr   = wrAddrQ;
    assign writeData   = wrDataQ;
    assign count       = countQ;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;
    localparam int unsigned WL = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p_valid = 1'b0;
    logic [RW-1:0] p_addr = '0;
    logic [WL-1:0] p_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [RW-1:0] s_addr = '0;
    logic [WL-1:0] s_data = '0;
    logic          writeEnable;
    logic [RW-1:0] writeAddr;
    logic [WL-1:0] writeData;
    logic [RW-1:0] qAddr1 = '0;
    logic [RW-1:0] qAddr2 = '0;
    logic          qPending1;
    logic          qPending2;
    logic [$clog2(DP):0] count;

    writeback_arbiter #(.WORD_LEN(WL), .REG_IDX_WIDTH(RW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .qAddr1(qAddr1), .qAddr2(qAddr2), .qPending1(qPending1), .qPending2(qPending2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] addr;
        logic [WL-1:0] data;
        bit            killed;
    } ent_t;

    ent_t          mq[$];
    logic          expWe;
    logic [RW-1:0] expWa;
    logic [WL-1:0] expWd;
    bit            lastAccept;
    logic [RW-1:0] wrLog[$];
    logic [WL-1:0] rf[32];
    int            nChecks = 0;
    int            nFail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelPending(input logic [RW-1:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == a && !mq[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mq.delete();
        expWe = 1'b0;
        expWa = '0;
        expWd = '0;
    endtask

    // Advance the model by one clock edge using the currently applied inputs
    task automatic modelStep();
        ent_t e;
        lastAccept = s_valid && (mq.size() != DP);
        if (p_valid && p_addr != 0) begin
            expWe = 1'b1; expWa = p_addr; expWd = p_data;
            foreach (mq[i]) if (mq[i].addr == p_addr) mq[i].killed = 1'b1;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            expWe = !e.killed;
            if (!e.killed) begin expWa = e.addr; expWd = e.data; end
        end else begin
            expWe = 1'b0;
        end
        if (lastAccept && s_addr != 0) begin
            e.addr = s_addr; e.data = s_data; e.killed = 1'b0;
            mq.push_back(e);
        end
    endtask

    // Compare every observable output against the model
    task automatic checkAll();
        chk("count", 64'(count), 64'(mq.size()));
        chk("s_ready", 64'(s_ready), 64'(mq.size() != DP));
        chk("qPending1", 64'(qPending1), 64'(modelPending(qAddr1)));
        chk("qPending2", 64'(qPending2), 64'(modelPending(qAddr2)));
        chk("writeEnable", 64'(writeEnable), 64'(expWe));
        chk("writeAddr", 64'(writeAddr), 64'(expWa));
        chk("writeData", 64'(writeData), 64'(expWd));
        if (writeEnable === 1'b1) begin
            wrLog.push_back(writeAddr);
            rf[writeAddr] = writeData;
        end
    endtask

    // One clock: drive after negedge, check before the next posedge, step model
    task automatic cycle(input logic pv, input logic [RW-1:0] pa, input logic [WL-1:0] pd,
                         input logic sv, input logic [RW-1:0] sa, input logic [WL-1:0] sd);
        @(negedge clk);
        p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        #1;
        checkAll();
        modelStep();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    int idx;
    int seen;
    logic [RW-1:0] want;

    initial begin
        foreach (rf[i]) rf[i] = '0;
        modelReset();

        // Reset state
        @(negedge clk); #1;
        chk("rst_we", 64'(writeEnable), 64'd0);
        chk("rst_wa", 64'(writeAddr), 64'd0);
        chk("rst_wd", 64'(writeData), 64'd0);
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_rdy", 64'(s_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Primary only: one-cycle latency, then idle
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle();
        chk("p_we", 64'(writeEnable), 64'd1);
        chk("p_wa", 64'(writeAddr), 64'd5);
        chk("p_wd", 64'(writeData), 64'hDEADBEEF);
        idle();
        chk("p_we_off", 64'(writeEnable), 64'd0);
        chk("p_wa_hold", 64'(writeAddr), 64'd5);

        // Fill and backpressure with primary held on addr 7
        idx = 1;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 5'd7, 32'h700, 1'b1, RW'(idx), WL'(idx * 16));
            if (lastAccept) idx++;
        end
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_rdy", 64'(s_ready), 64'd0);
        chk("full_held", 64'(idx), 64'd5);
        wrLog.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, '0, idx <= 5, RW'(idx), WL'(idx * 16));
            if (lastAccept) idx++;
        end
        seen = 0;
        want = 5'd1;
        foreach (wrLog[i]) begin
            if (wrLog[i] != 5'd7) begin
                chk("drain_order", 64'(wrLog[i]), 64'(want));
                want++;
                seen++;
            end
        end
        chk("drain_cnt", 64'(seen), 64'd5);

        // Kill: queued addr 3 overtaken by primary write to 3
        qAddr1 = 5'd3;
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h11);
        cycle(1'b1, 5'd3, 32'h22, 1'b0, '0, '0);
        chk("kill_pend_before", 64'(qPending1), 64'd1);
        idle();
        chk("kill_pend_after", 64'(qPending1), 64'd0);
        chk("kill_p_wd", 64'(writeData), 64'h22);
        idle();
        chk("kill_pop_we", 64'(writeEnable), 64'd0);
        chk("kill_pop_cnt", 64'(count), 64'd0);
        idle();
        chk("kill_rf", 64'(rf[3]), 64'h22);

        // x0 handling
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hAA);
        chk("x0_rdy", 64'(s_ready), 64'd1);
        idle();
        chk("x0_cnt", 64'(count), 64'd0);
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'h66);
        cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
        idle();
        chk("x0p_we", 64'(writeEnable), 64'd1);
        chk("x0p_wa", 64'(writeAddr), 64'd6);
        chk("x0p_wd", 64'(writeData), 64'h66);

        // Reset mid-drain with three queued entries
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd9, 32'h9, 1'b1, RW'(i + 10), WL'(i));
        chk("pre_rst_cnt", 64'(count), 64'd2);
        @(negedge clk);
        p_valid = 1'b0; s_valid = 1'b0;
        #1;
        chk("mid_cnt3", 64'(count), 64'd3);
        reset = 1'b1;
        #1;
        chk("mrst_we", 64'(writeEnable), 64'd0);
        chk("mrst_wa", 64'(writeAddr), 64'd0);
        chk("mrst_wd", 64'(writeData), 64'd0);
        chk("mrst_cnt", 64'(count), 64'd0);
        chk("mrst_rdy", 64'(s_ready), 64'd1);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        wrLog.delete();
        for (int i = 0; i < 5; i++) idle();
        chk("post_rst_writes", 64'(wrLog.size()), 64'd0);
        chk("post_rst_rdy", 64'(s_ready), 64'd1);

        // Randomized traffic over a small address range to provoke kills
        for (int i = 0; i < 3000; i++) begin
            qAddr1 = RW'($urandom_range(0, 7));
            qAddr2 = RW'($urandom_range(0, 7));
            cycle($urandom_range(0, 99) < 35, RW'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 99) < 60, RW'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter REG_IDX_WIDTH, default 5, meaning register index width.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of two, at least 2), meaning secondary-queue entries.
REQ-004 The block SHALL have port clk  in  1  meaning single clock; all state updates on posedge.
REQ-005 The block SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-006 The block SHALL have ports p_valid  in  1, p_addr  in  REG_IDX_WIDTH and p_data  in  WORD_LEN, meaning the primary (ALU pipeline) write request, which has no backpressure.
REQ-007 The block SHALL have ports s_valid  in  1, s_ready  out  1, s_addr  in  REG_IDX_WIDTH and s_data  in  WORD_LEN, meaning the secondary (multi-cycle unit) write request with valid/ready handshake.
REQ-008 The block SHALL have ports writeEnable  out  1, writeAddr  out  REG_IDX_WIDTH and writeData  out  WORD_LEN, meaning the registered drive to the register-file write port.
REQ-009 The block SHALL have ports qAddr1 and qAddr2, each in  REG_IDX_WIDTH, and qPending1 and qPending2, each out  1, meaning the decode hazard query.
REQ-010 The block SHALL have port count  out  log2(DEPTH)+1  meaning current queue occupancy.

Function
REQ-011 Secondary accept: a transfer SHALL occur when s_valid && s_ready; s_ready SHALL equal (count != DEPTH), depend only on registered state, and stay 0 when full even if a pop occurs that cycle.
REQ-012 An accepted secondary write with s_addr==0 SHALL complete the handshake but not be enqueued.
REQ-013 An accepted secondary write with s_addr!=0 SHALL be enqueued at the tail with its kill bit clear.
REQ-014 A primary request SHALL be effective only when p_valid && p_addr!=0.
REQ-015 Each cycle the arbiter SHALL select, in priority order: an effective primary request, else the queue head if count>0, else nothing.
REQ-016 Selection SHALL be registered: writeEnable/writeAddr/writeData reflect the choice made at posedge N during the cycle after N, stable across the register-file negedge write.
REQ-017 The primary write SHALL have a latency of exactly 1 cycle.
REQ-018 A secondary entry pushed at edge N SHALL NOT be popped before edge N+1; queue bypass is forbidden.
REQ-019 When nothing is selected, writeEnable SHALL be 0 and writeAddr/writeData SHALL hold their previous values.
REQ-020 Ordering kill: on an effective primary write to address A, every valid queued entry with address A SHALL have its kill bit set.
REQ-021 An entry enqueued in the same cycle as a primary write to the same A SHALL count as younger and SHALL NOT be killed.
REQ-022 Popping a killed entry SHALL consume the pop slot, drive writeEnable=0 that cycle and decrement count.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-025 qPendingK SHALL be combinational: 1 iff qAddrK!=0 and some valid, non-killed queued entry has address qAddrK; the output register is not included.
REQ-026 Pointers plus count SHALL distinguish full from empty unambiguously.

Reset
REQ-027 While reset=1, writeEnable, writeAddr, writeData, count, pointers and all valid/kill bits SHALL be 0, s_ready SHALL be 1 and qPending1/2 SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; no write SHALL issue after reset from pre-reset requests.

Verification
REQ-029 Primary only: p_valid=1, p_addr=5, p_data=0xDEADBEEF at edge N -> writeEnable=1, writeAddr=5, writeData=0xDEADBEEF after edge N, and writeEnable=0 after N+1 if idle.
REQ-030 Fill/backpressure: 5 back-to-back secondary pushes (addr 1..5) with p_valid held on addr 7 -> first 4 accepted, s_ready=0 with count=4, 5th held; on dropping p_valid the entries drain in order 1,2,3,4 then 5.
REQ-031 Kill: queue holds addr 3 (data 0x11); primary writes addr 3 (data 0x22) -> qPending for 3 falls to 0, the later pop of 0x11 shows writeEnable=0 and the register-file content stays 0x22.
REQ-032 x0: secondary push addr 0 -> handshake completes and count is unchanged; primary addr 0 with a nonempty queue -> the queue head is written that cycle.
REQ-033 Reset mid-drain: count=3, assert reset between edges -> outputs go to 0 immediately; after release no writes occur and s_ready=1.
